// File: rtl/mem_writeback_stage.sv
// Pipeline stage 4: ALU writeback plus data-memory loads/stores over a req/ack handshake.
// Define MEM_TIMEOUT_EN to abort memory accesses that receive no ack within TIMEOUT cycles.
`timescale 1ns/1ps
module mem_writeback_stage #(
  parameter int ADDR_W  = 10,
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              ex_is_load,
  input  logic              ex_is_store,
  input  logic [2:0]        ex_funct3,
  input  logic [4:0]        ex_rdt,
  input  logic [ADDR_W-1:0] ex_mem_address,
  input  logic [XLEN-1:0]   ex_result,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ack,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              misaligned,
  output logic              mem_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, LOADWB} state_t;

  // Lane replication and strobes assume a 32-bit, 4-byte data bus.
  if (XLEN != 32) begin : g_bad_xlen
    $error("mem_writeback_stage supports XLEN == 32 only");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  state_t state, state_nxt;

  // Context of the access in flight, needed to extend load data at ack time.
  logic       pend_load,   pend_load_d;
  logic [2:0] pend_funct3, pend_funct3_d;
  logic [1:0] pend_off,    pend_off_d;
  logic [4:0] pend_rdt,    pend_rdt_d;

  logic              mem_req_d, mem_we_d, rf_we_d, misaligned_d, mem_err_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [XLEN-1:0]   mem_wdata_d, rf_wdata_d;
  logic [3:0]        mem_wstrb_d;
  logic [4:0]        rf_waddr_d;

  logic            accept, is_mem, addr_bad, timeout_hit;
  logic [1:0]      off;
  logic [XLEN-1:0] st_wdata, ld_data;
  logic [3:0]      st_wstrb;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;

  assign off      = ex_mem_address[1:0];
  assign ex_ready = (state == IDLE);
  assign accept   = ex_valid && ex_ready;
  assign is_mem   = ex_is_load || ex_is_store;

  // NOTE: every signal written in an always_comb gets a value on every path
  // (a default or a full case), otherwise synthesis infers a latch.
  always_comb begin
    unique case (ex_funct3[1:0])
      2'b01:   addr_bad = off[0];
      2'b10:   addr_bad = |off;
      default: addr_bad = 1'b0;
    endcase
  end

  always_comb begin
    unique case (ex_funct3[1:0])
      2'b00: begin
        st_wdata = {4{ex_result[7:0]}};
        st_wstrb = 4'b0001 << off;
      end
      2'b01: begin
        st_wdata = {2{ex_result[15:0]}};
        st_wstrb = 4'b0011 << off;
      end
      default: begin
        st_wdata = ex_result;
        st_wstrb = 4'b1111;
      end
    endcase
  end

  always_comb begin
    unique case (pend_off)
      2'd0: ld_byte = mem_rdata[7:0];
      2'd1: ld_byte = mem_rdata[15:8];
      2'd2: ld_byte = mem_rdata[23:16];
      2'd3: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = pend_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    unique case (pend_funct3)
      3'b000:  ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b100:  ld_data = {{(XLEN-8){1'b0}}, ld_byte};
      3'b101:  ld_data = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;

  // Counts ACCESS cycles without ack; held at zero outside ACCESS.
  always_ff @(posedge clk) begin
    if (!rst_n || state != ACCESS) begin
      wait_cnt <= '0;
    end else if (!mem_ack) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign timeout_hit = !mem_ack && (wait_cnt == CNT_W'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // NOTE: reset is sampled on the clock edge, so it belongs inside the
  // clocked block rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept && is_mem && !addr_bad) state_nxt = ACCESS;
      end
      ACCESS: begin
        if (mem_ack)          state_nxt = pend_load ? LOADWB : IDLE;
        else if (timeout_hit) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_req_d     = mem_req;
    mem_we_d      = mem_we;
    mem_addr_d    = mem_addr;
    mem_wdata_d   = mem_wdata;
    mem_wstrb_d   = mem_wstrb;
    rf_we_d       = 1'b0;
    rf_waddr_d    = rf_waddr;
    rf_wdata_d    = rf_wdata;
    misaligned_d  = 1'b0;
    mem_err_d     = 1'b0;
    pend_load_d   = pend_load;
    pend_funct3_d = pend_funct3;
    pend_off_d    = pend_off;
    pend_rdt_d    = pend_rdt;
    unique case (state)
      IDLE: begin
        if (accept && !is_mem) begin
          rf_we_d    = (ex_rdt != 5'd0);
          rf_waddr_d = ex_rdt;
          rf_wdata_d = ex_result;
        end else if (accept && addr_bad) begin
          misaligned_d = 1'b1;
        end else if (accept) begin
          // A load flagged as store too is issued as the store.
          mem_req_d     = 1'b1;
          mem_we_d      = ex_is_store;
          mem_addr_d    = {ex_mem_address[ADDR_W-1:2], 2'b00};
          mem_wdata_d   = ex_is_store ? st_wdata : '0;
          mem_wstrb_d   = ex_is_store ? st_wstrb : 4'b0000;
          pend_load_d   = !ex_is_store;
          pend_funct3_d = ex_funct3;
          pend_off_d    = off;
          pend_rdt_d    = ex_rdt;
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          if (pend_load) begin
            rf_we_d    = (pend_rdt != 5'd0);
            rf_waddr_d = pend_rdt;
            rf_wdata_d = ld_data;
          end
        end else if (timeout_hit) begin
          mem_req_d = 1'b0;
          mem_err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_wstrb   <= '0;
      rf_we       <= 1'b0;
      rf_waddr    <= '0;
      rf_wdata    <= '0;
      misaligned  <= 1'b0;
      mem_err     <= 1'b0;
      pend_load   <= 1'b0;
      pend_funct3 <= '0;
      pend_off    <= '0;
      pend_rdt    <= '0;
    end else begin
      mem_req     <= mem_req_d;
      mem_we      <= mem_we_d;
      mem_addr    <= mem_addr_d;
      mem_wdata   <= mem_wdata_d;
      mem_wstrb   <= mem_wstrb_d;
      rf_we       <= rf_we_d;
      rf_waddr    <= rf_waddr_d;
      rf_wdata    <= rf_wdata_d;
      misaligned  <= misaligned_d;
      mem_err     <= mem_err_d;
      pend_load   <= pend_load_d;
      pend_funct3 <= pend_funct3_d;
      pend_off    <= pend_off_d;
      pend_rdt    <= pend_rdt_d;
    end
  end

endmodule

// File: tb/tb_mem_writeback_stage.sv
// Directed testbench for mem_writeback_stage with hand-computed expectations.
// The timeout scenario follows MEM_TIMEOUT_EN, matching the design build.
`timescale 1ns/1ps
module tb_mem_writeback_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0, ex_ready;
  logic        ex_is_load = 1'b0, ex_is_store = 1'b0;
  logic [2:0]  ex_funct3 = '0;
  logic [4:0]  ex_rdt = '0;
  logic [9:0]  ex_mem_address = '0;
  logic [31:0] ex_result = '0;
  logic        mem_req, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        misaligned, mem_err;

  int total = 0;
  int bad = 0;

  mem_writeback_stage #(.ADDR_W(10), .XLEN(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
    .ex_funct3(ex_funct3), .ex_rdt(ex_rdt),
    .ex_mem_address(ex_mem_address), .ex_result(ex_result),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .misaligned(misaligned), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [4:0] rdt, input logic [9:0] addr, input logic [31:0] res);
    ex_valid = 1'b1; ex_is_load = ld; ex_is_store = st; ex_funct3 = f3;
    ex_rdt = rdt; ex_mem_address = addr; ex_result = res;
  endtask

  task automatic drive_idle();
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    total++; if ({mem_req, mem_we, rf_we, misaligned, mem_err} !== 5'b0) begin bad++;
      $display("FAIL reset_ctrl got=%b exp=00000", {mem_req, mem_we, rf_we, misaligned, mem_err}); end
    total++; if ({mem_addr, mem_wdata, mem_wstrb, rf_waddr, rf_wdata} !== '0) begin bad++;
      $display("FAIL reset_data addr=%h wdata=%h wstrb=%b waddr=%0d rdata=%h exp all 0", mem_addr, mem_wdata, mem_wstrb, rf_waddr, rf_wdata); end
    total++; if (ex_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", ex_ready); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_alu_back_to_back();
    drive_op(1'b0, 1'b0, 3'b000, 5'd5, 10'h000, 32'h0000_1234);
    total++; if (ex_ready !== 1'b1) begin bad++; $display("FAIL alu_ready0 got=%b exp=1", ex_ready); end
    tick();
    total++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'h0000_1234}) begin bad++;
      $display("FAIL alu_wb0 we=%b waddr=%0d wdata=%h exp we=1 waddr=5 wdata=00001234", rf_we, rf_waddr, rf_wdata); end
    drive_op(1'b0, 1'b0, 3'b000, 5'd6, 10'h000, 32'h0000_ABCD);
    total++; if (ex_ready !== 1'b1) begin bad++; $display("FAIL alu_ready1 got=%b exp=1", ex_ready); end
    tick();
    drive_idle();
    total++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd6, 32'h0000_ABCD}) begin bad++;
      $display("FAIL alu_wb1 we=%b waddr=%0d wdata=%h exp we=1 waddr=6 wdata=0000abcd", rf_we, rf_waddr, rf_wdata); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL alu_no_req got=%b exp=0", mem_req); end
    tick();
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL alu_we_drop got=%b exp=0", rf_we); end
  endtask

  task automatic test_lb_signed();
    drive_op(1'b1, 1'b0, 3'b000, 5'd7, 10'h103, 32'h0);
    tick();
    drive_idle();
    total++; if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 10'h100}) begin bad++;
      $display("FAIL lb_req req=%b we=%b addr=%h exp req=1 we=0 addr=100", mem_req, mem_we, mem_addr); end
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (mem_req !== 1'b1 || ex_ready !== 1'b0 || rf_we !== 1'b0) begin bad++;
        $display("FAIL lb_wait%0d req=%b ready=%b we=%b exp 1 0 0", i, mem_req, ex_ready, rf_we); end
    end
    mem_ack = 1'b1; mem_rdata = 32'h80FF_FF7F;
    tick();
    mem_ack = 1'b0;
    total++; if ({mem_req, rf_we, rf_waddr, rf_wdata} !== {1'b0, 1'b1, 5'd7, 32'hFFFF_FF80}) begin bad++;
      $display("FAIL lb_wb req=%b we=%b waddr=%0d wdata=%h exp req=0 we=1 waddr=7 wdata=ffffff80", mem_req, rf_we, rf_waddr, rf_wdata); end
    total++; if (ex_ready !== 1'b0) begin bad++; $display("FAIL lb_ready_loadwb got=%b exp=0", ex_ready); end
    tick();
    total++; if (rf_we !== 1'b0 || ex_ready !== 1'b1) begin bad++;
      $display("FAIL lb_done we=%b ready=%b exp we=0 ready=1", rf_we, ex_ready); end
  endtask

  task automatic test_load_ext();
    logic [2:0]  f3  [6] = '{3'b101, 3'b001, 3'b100, 3'b010, 3'b011, 3'b000};
    logic [9:0]  ad  [6] = '{10'h006, 10'h004, 10'h001, 10'h008, 10'h00E, 10'h002};
    logic [31:0] rd  [6] = '{32'h8001_1234, 32'h0000_F00D, 32'h0000_9A00, 32'hCAFE_BABE, 32'h1357_9BDF, 32'h007F_0000};
    logic [31:0] exp [6] = '{32'h0000_8001, 32'hFFFF_F00D, 32'h0000_009A, 32'hCAFE_BABE, 32'h1357_9BDF, 32'h0000_007F};
    logic [9:0]  ea  [6] = '{10'h004, 10'h004, 10'h000, 10'h008, 10'h00C, 10'h000};
    for (int i = 0; i < 6; i++) begin
      drive_op(1'b1, 1'b0, f3[i], 5'd10, ad[i], 32'h0);
      tick();
      drive_idle();
      total++; if (mem_req !== 1'b1 || mem_addr !== ea[i]) begin bad++;
        $display("FAIL ld%0d_req req=%b addr=%h exp req=1 addr=%h", i, mem_req, mem_addr, ea[i]); end
      mem_ack = 1'b1; mem_rdata = rd[i];
      tick();
      mem_ack = 1'b0;
      total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd10 || rf_wdata !== exp[i]) begin bad++;
        $display("FAIL ld%0d_wb we=%b waddr=%0d wdata=%h exp we=1 waddr=10 wdata=%h", i, rf_we, rf_waddr, rf_wdata, exp[i]); end
      tick();
      total++; if (ex_ready !== 1'b1 || rf_we !== 1'b0) begin bad++;
        $display("FAIL ld%0d_idle ready=%b we=%b exp ready=1 we=0", i, ex_ready, rf_we); end
    end
  endtask

  task automatic test_store();
    logic        ld  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [2:0]  f3  [4] = '{3'b001, 3'b000, 3'b010, 3'b000};
    logic [9:0]  ad  [4] = '{10'h002, 10'h005, 10'h3FC, 10'h013};
    logic [31:0] dat [4] = '{32'hDEAD_BEEF, 32'h1234_56A5, 32'h0BAD_F00D, 32'h0000_0077};
    logic [9:0]  ea  [4] = '{10'h000, 10'h004, 10'h3FC, 10'h010};
    logic [31:0] ew  [4] = '{32'hBEEF_BEEF, 32'hA5A5_A5A5, 32'h0BAD_F00D, 32'h7777_7777};
    logic [3:0]  es  [4] = '{4'b1100, 4'b0010, 4'b1111, 4'b1000};
    for (int i = 0; i < 4; i++) begin
      drive_op(ld[i], 1'b1, f3[i], 5'd2, ad[i], dat[i]);
      tick();
      drive_idle();
      total++; if ({mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb} !== {1'b1, 1'b1, ea[i], ew[i], es[i]}) begin bad++;
        $display("FAIL st%0d_req req=%b we=%b addr=%h wdata=%h wstrb=%b exp 1 1 %h %h %b", i, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, ea[i], ew[i], es[i]); end
      tick();
      total++; if ({mem_req, mem_addr, mem_wdata, mem_wstrb} !== {1'b1, ea[i], ew[i], es[i]} || ex_ready !== 1'b0) begin bad++;
        $display("FAIL st%0d_hold req=%b addr=%h wdata=%h wstrb=%b ready=%b", i, mem_req, mem_addr, mem_wdata, mem_wstrb, ex_ready); end
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      total++; if (mem_req !== 1'b0 || rf_we !== 1'b0 || ex_ready !== 1'b1) begin bad++;
        $display("FAIL st%0d_done req=%b we=%b ready=%b exp 0 0 1", i, mem_req, rf_we, ex_ready); end
    end
  endtask

  task automatic test_misaligned();
    drive_op(1'b1, 1'b0, 3'b010, 5'd9, 10'h006, 32'h0);
    tick();
    total++; if ({misaligned, mem_req, rf_we, ex_ready} !== 4'b1001) begin bad++;
      $display("FAIL mis_lw mis=%b req=%b we=%b ready=%b exp 1 0 0 1", misaligned, mem_req, rf_we, ex_ready); end
    drive_op(1'b0, 1'b0, 3'b000, 5'd3, 10'h000, 32'h0000_0055);
    tick();
    total++; if ({misaligned, rf_we, rf_waddr, rf_wdata} !== {1'b0, 1'b1, 5'd3, 32'h55}) begin bad++;
      $display("FAIL mis_next mis=%b we=%b waddr=%0d wdata=%h exp 0 1 3 00000055", misaligned, rf_we, rf_waddr, rf_wdata); end
    drive_op(1'b0, 1'b1, 3'b001, 5'd0, 10'h001, 32'h1111_2222);
    tick();
    drive_idle();
    total++; if ({misaligned, mem_req} !== 2'b10) begin bad++;
      $display("FAIL mis_sh mis=%b req=%b exp 1 0", misaligned, mem_req); end
    tick();
    total++; if ({misaligned, mem_req} !== 2'b00) begin bad++;
      $display("FAIL mis_pulse mis=%b req=%b exp 0 0", misaligned, mem_req); end
  endtask

  task automatic test_rdt_zero();
    drive_op(1'b0, 1'b0, 3'b000, 5'd0, 10'h000, 32'h0000_FFFF);
    tick();
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL x0_alu we=%b exp=0", rf_we); end
    drive_op(1'b1, 1'b0, 3'b010, 5'd0, 10'h010, 32'h0);
    tick();
    drive_idle();
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL x0_ld_req got=%b exp=1", mem_req); end
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_ack = 1'b0;
    total++; if ({mem_req, rf_we, ex_ready} !== 3'b000) begin bad++;
      $display("FAIL x0_ld_wb req=%b we=%b ready=%b exp 0 0 0", mem_req, rf_we, ex_ready); end
    tick();
    total++; if ({rf_we, ex_ready} !== 2'b01) begin bad++;
      $display("FAIL x0_ld_idle we=%b ready=%b exp 0 1", rf_we, ex_ready); end
  endtask

  task automatic test_ack_outside();
    mem_ack = 1'b1; mem_rdata = 32'h0000_0005;
    tick();
    mem_ack = 1'b0;
    total++; if ({mem_req, rf_we, ex_ready} !== 3'b001) begin bad++;
      $display("FAIL stray_ack req=%b we=%b ready=%b exp 0 0 1", mem_req, rf_we, ex_ready); end
  endtask

  task automatic test_reset_mid_access();
    drive_op(1'b1, 1'b0, 3'b010, 5'd8, 10'h040, 32'h0);
    tick();
    drive_idle();
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL rstmid_req got=%b exp=1", mem_req); end
    rst_n = 1'b0;
    tick();
    total++; if ({mem_req, mem_we, rf_we, misaligned, mem_err} !== 5'b0) begin bad++;
      $display("FAIL rstmid_ctrl got=%b exp=00000", {mem_req, mem_we, rf_we, misaligned, mem_err}); end
    total++; if ({mem_addr, mem_wdata, mem_wstrb, rf_waddr, rf_wdata} !== '0 || ex_ready !== 1'b1) begin bad++;
      $display("FAIL rstmid_data addr=%h wdata=%h wstrb=%b waddr=%0d rdata=%h ready=%b", mem_addr, mem_wdata, mem_wstrb, rf_waddr, rf_wdata, ex_ready); end
    rst_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'h0000_0099;
    tick();
    mem_ack = 1'b0;
    total++; if ({mem_req, rf_we, ex_ready} !== 3'b001) begin bad++;
      $display("FAIL rstmid_late_ack req=%b we=%b ready=%b exp 0 0 1", mem_req, rf_we, ex_ready); end
  endtask

  task automatic test_access_wait();
    drive_op(1'b1, 1'b0, 3'b010, 5'd4, 10'h020, 32'h0);
    tick();
    drive_idle();
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL wait_req got=%b exp=1", mem_req); end
`ifdef MEM_TIMEOUT_EN
    for (int i = 1; i < 16; i++) begin
      tick();
      total++; if (mem_req !== 1'b1 || mem_err !== 1'b0) begin bad++;
        $display("FAIL to_wait%0d req=%b err=%b exp 1 0", i, mem_req, mem_err); end
    end
    tick();
    total++; if ({mem_err, mem_req, rf_we, ex_ready} !== 4'b1001) begin bad++;
      $display("FAIL to_abort err=%b req=%b we=%b ready=%b exp 1 0 0 1", mem_err, mem_req, rf_we, ex_ready); end
    tick();
    total++; if (mem_err !== 1'b0) begin bad++; $display("FAIL to_pulse err=%b exp=0", mem_err); end
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      total++; if (mem_req !== 1'b1 || mem_err !== 1'b0 || ex_ready !== 1'b0) begin bad++;
        $display("FAIL nowait%0d req=%b err=%b ready=%b exp 1 0 0", i, mem_req, mem_err, ex_ready); end
    end
    mem_ack = 1'b1; mem_rdata = 32'h0000_0042;
    tick();
    mem_ack = 1'b0;
    total++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd4, 32'h42}) begin bad++;
      $display("FAIL nowait_wb we=%b waddr=%0d wdata=%h exp 1 4 00000042", rf_we, rf_waddr, rf_wdata); end
    tick();
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu_back_to_back();
    test_lb_signed();
    test_load_ext();
    test_store();
    test_misaligned();
    test_rdt_zero();
    test_ack_outside();
    test_reset_mid_access();
    test_access_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_writeback_stage.md
Name: mem_writeback_stage

Overview:
- Stage 4 of the pipeline. Consumes Execute results and performs data-memory loads and stores over a req/ack handshake.
- Writes ALU and load results to the register file through a single write port.
- Stalls Execute via `ex_ready` while a memory access is outstanding.

Parameters:
- ADDR_W, 10, byte-address width of the data memory.
- XLEN, 32, data and register width.
- TIMEOUT, 16, cycles to wait for `mem_ack` before aborting (used only with `MEM_TIMEOUT_EN`).

Ports:
- clk  in  1  pipeline clock.
- Reset  in  1  one clock; reset is synchronous and active-low (sampled on rising clk, 0 = reset).
- ex_valid  in  1  Execute presents an operation.
- ex_ready  out  1  stage can accept; transfer happens when ex_valid && ex_ready at a rising edge.
- ex_is_load  in  1  operation is a load.
- ex_is_store  in  1  operation is a store.
- ex_funct3  in  3  access size/sign (RV32I encoding).
- ex_rdt  in  5  destination register.
- ex_mem_address  in  ADDR_W  byte address for load/store.
- ex_result  in  XLEN  ALU result, or store data when ex_is_store.
- mem_req  out  1  memory request, held until ack.
- mem_we  out  1  1 = store.
- mem_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00}).
- mem_wdata  out  XLEN  store data, lane-replicated.
- mem_wstrb  out  4  byte enables.
- mem_ack  in  1  one-cycle completion pulse.
- mem_rdata  in  XLEN  load word, valid with mem_ack.
- rf_we  out  1  register-file write strobe.
- rf_waddr  out  5  write register index.
- rf_wdata  out  XLEN  write data.
- misaligned  out  1  one-cycle pulse on a misaligned access.
- mem_err  out  1  one-cycle pulse on a timeout abort (`MEM_TIMEOUT_EN` only; else tied 0).

Behaviour:
- States: IDLE, ACCESS, LOADWB.
- Reset values: state=IDLE; mem_req, mem_we, rf_we, misaligned, mem_err = 0; all address and data outputs = 0.
- ex_ready = 1 only in IDLE.
- ALU op (neither load nor store), accepted in IDLE:
  - Next cycle: rf_we=1, rf_waddr=ex_rdt, rf_wdata=ex_result.
  - State stays IDLE; throughput 1/cycle, latency 1.
- ex_is_load and ex_is_store both 1: treated as store.
- Alignment check at acceptance:
  - funct3[1:0]=01 (half) needs addr[0]=0; =10 (word) needs addr[1:0]=00.
  - Violation: misaligned=1 for one cycle, no memory request, no register write, stay IDLE.
- Valid load/store accepted: next cycle mem_req=1 and state=ACCESS. mem_addr, mem_we, mem_wdata and mem_wstrb are registered and stay stable until ack.
- Store byte (SB): wdata={4{data[7:0]}}, wstrb=0001<<addr[1:0].
- Store half (SH): wdata={2{data[15:0]}}, wstrb=0011<<addr[1:0].
- Store word (SW): wdata=data, wstrb=1111.
- ACCESS + mem_ack, store: mem_req=0 at the same edge, go to IDLE, no register write.
- ACCESS + mem_ack, load:
  - Capture mem_rdata, select lane by addr[1:0].
  - Extend per funct3: 000 LB sign, 001 LH sign, 010 LW, 100 LBU zero, 101 LHU zero. Other codes behave as LW.
  - Go to LOADWB.
- LOADWB: rf_we=1 for one cycle with the extended data, then IDLE. A new op can be accepted one cycle after LOADWB; load-to-accept minimum is 3 cycles when ack is same-cycle.
- rdt=0: rf_we is suppressed for both ALU ops and loads (x0 stays 0).
- mem_ack outside ACCESS: ignored.
- Reset asserted in any state, including mid-ACCESS: at that edge mem_req drops, the pending op is discarded with no rf write, state=IDLE.

Optional Feature:
- Macro `MEM_TIMEOUT_EN`.
- Defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle without ack.
  - On reaching TIMEOUT: mem_req drops, mem_err pulses 1 cycle, no rf write, state=IDLE.
  - An ack arriving in the same cycle as the timeout wins.
- Undefined: no counter; ACCESS waits indefinitely; mem_err tied 0.

Test Plan:
- ALU back-to-back: ops rdt=5 result 0x1234, then rdt=6 0xABCD on consecutive cycles → rf_we on the two following cycles with matching addr/data; ex_ready stays 1.
- LB signed: addr 0x103, funct3=000, mem_rdata=0x80FF_FF7F, ack after 3 cycles → mem_addr=0x100; rf_wdata=0xFFFF_FF80; ex_ready=0 until back in IDLE.
- SH at addr 0x002, data 0xDEAD_BEEF → mem_we=1, wstrb=1100, wdata=0xBEEF_BEEF; no rf_we.
- Misaligned LW at addr 0x006 → misaligned pulse, mem_req stays 0, rf_we stays 0; next ALU op accepted the following cycle.
- Load to rdt=0 → memory access completes, rf_we stays 0. Reset driven low mid-ACCESS → next edge mem_req=0, all outputs 0, later ack ignored.
- `MEM_TIMEOUT_EN`, TIMEOUT=16, mem_ack never asserted → mem_err pulses 16 cycles after mem_req rose; stage returns to IDLE.
